// File: rtl/unit_test_run_scheduler.sv
// Sequences enabled hardware test slots one at a time, times each out if needed,
// and streams per-test results to a logger while keeping pass/fail/timeout tallies.
module unit_test_run_scheduler #(
    parameter int NUM_TESTS = 8,
    parameter int TMO_W     = 16,
    parameter int ID_W      = $clog2(NUM_TESTS),
    parameter int CNT_W     = $clog2(NUM_TESTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_TESTS-1:0] enable_mask,
    input  logic [TMO_W-1:0]     timeout_cycles,
    input  logic                 abort_req,
    output logic                 test_start,
    output logic                 test_abort,
    output logic [ID_W-1:0]      test_id,
    input  logic                 test_done,
    input  logic                 test_pass,
    output logic                 log_valid,
    input  logic                 log_ready,
    output logic [ID_W-1:0]      log_id,
    output logic [1:0]           log_status,
    output logic                 busy,
    output logic                 run_done,
    output logic                 all_pass,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     fail_count,
    output logic [CNT_W-1:0]     timeout_count
);

    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_LAUNCH, S_WAIT, S_LOG, S_FINISH
    } state_t;

    state_t               state, state_nxt;
    logic [NUM_TESTS-1:0] pending, pending_nxt;
    logic [ID_W-1:0]      idx, idx_nxt;
    logic [TMO_W-1:0]     tmo, tmo_nxt;
    logic [TMO_W-1:0]     timer, timer_nxt, timer_inc;
    logic                 abort_flag, abort_nxt;
    logic                 test_start_nxt, test_abort_nxt, log_valid_nxt;
    logic                 busy_nxt, run_done_nxt, all_pass_nxt;
    logic [ID_W-1:0]      log_id_nxt;
    logic [1:0]           log_status_nxt;
    logic [CNT_W-1:0]     pass_nxt, fail_nxt, tmo_cnt_nxt;

    // Timer counts cycles since the launch pulse and parks at all-ones.
    assign timer_inc = (timer == '1) ? timer : timer + TMO_W'(1);
    assign test_id   = idx;

    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending;
        idx_nxt        = idx;
        tmo_nxt        = tmo;
        timer_nxt      = timer;
        abort_nxt      = abort_flag;
        test_start_nxt = 1'b0;
        test_abort_nxt = 1'b0;
        log_valid_nxt  = 1'b0;
        run_done_nxt   = 1'b0;
        busy_nxt       = busy;
        all_pass_nxt   = all_pass;
        log_id_nxt     = log_id;
        log_status_nxt = log_status;
        pass_nxt       = pass_count;
        fail_nxt       = fail_count;
        tmo_cnt_nxt    = timeout_count;

        if (busy && abort_req) abort_nxt = 1'b1;

        case (state)
            S_IDLE: begin
                if (start) begin
                    pending_nxt  = enable_mask;
                    tmo_nxt      = timeout_cycles;
                    idx_nxt      = '0;
                    abort_nxt    = 1'b0;
                    all_pass_nxt = 1'b0;
                    pass_nxt     = '0;
                    fail_nxt     = '0;
                    tmo_cnt_nxt  = '0;
                    busy_nxt     = 1'b1;
                    state_nxt    = S_SELECT;
                end
            end
            S_SELECT: begin
                // pending holds only slots at or above idx, so empty means the run is over.
                if (abort_flag || pending == '0) begin
                    run_done_nxt = 1'b1;
                    busy_nxt     = 1'b0;
                    all_pass_nxt = (fail_count == '0) && (timeout_count == '0);
                    state_nxt    = S_FINISH;
                end else if (!pending[idx]) begin
                    idx_nxt = idx + ID_W'(1);
                end else begin
                    test_start_nxt = 1'b1;
                    timer_nxt      = '0;
                    state_nxt      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_nxt = timer_inc;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                timer_nxt = timer_inc;
                if (test_done) begin
                    log_status_nxt = test_pass ? ST_PASS : ST_FAIL;
                    log_id_nxt     = idx;
                    log_valid_nxt  = 1'b1;
                    state_nxt      = S_LOG;
                end else if (tmo != '0 && timer >= tmo - TMO_W'(1)) begin
                    test_abort_nxt = 1'b1;
                    log_status_nxt = ST_TIMEOUT;
                    log_id_nxt     = idx;
                    log_valid_nxt  = 1'b1;
                    state_nxt      = S_LOG;
                end
            end
            S_LOG: begin
                log_valid_nxt = 1'b1;
                if (log_ready) begin
                    log_valid_nxt = 1'b0;
                    case (log_status)
                        ST_PASS: pass_nxt    = pass_count + CNT_W'(1);
                        ST_FAIL: fail_nxt    = fail_count + CNT_W'(1);
                        default: tmo_cnt_nxt = timeout_count + CNT_W'(1);
                    endcase
                    pending_nxt = pending & ~(NUM_TESTS'(1) << idx);
                    idx_nxt     = idx + ID_W'(1);
                    state_nxt   = S_SELECT;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            pending       <= '0;
            idx           <= '0;
            abort_flag    <= 1'b0;
            test_start    <= 1'b0;
            test_abort    <= 1'b0;
            log_valid     <= 1'b0;
            log_id        <= '0;
            log_status    <= '0;
            busy          <= 1'b0;
            run_done      <= 1'b0;
            all_pass      <= 1'b0;
            pass_count    <= '0;
            fail_count    <= '0;
            timeout_count <= '0;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            idx           <= idx_nxt;
            abort_flag    <= abort_nxt;
            test_start    <= test_start_nxt;
            test_abort    <= test_abort_nxt;
            log_valid     <= log_valid_nxt;
            log_id        <= log_id_nxt;
            log_status    <= log_status_nxt;
            busy          <= busy_nxt;
            run_done      <= run_done_nxt;
            all_pass      <= all_pass_nxt;
            pass_count    <= pass_nxt;
            fail_count    <= fail_nxt;
            timeout_count <= tmo_cnt_nxt;
        end
    end

    // Timeout value and timer are only consumed after being loaded, so they carry no reset.
    always_ff @(posedge clk) begin
        tmo   <= tmo_nxt;
        timer <= timer_nxt;
    end

endmodule

// File: tb/tb_unit_test_run_scheduler.sv
// Randomized bench for unit_test_run_scheduler: a bench-side test engine and logger
// drive the DUT while a transaction-level model predicts every launch, log and tally.
module tb_unit_test_run_scheduler;

    localparam int NT = 4;
    localparam int TW = 16;
    localparam int IW = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort_req, test_done, test_pass, log_ready;
    logic [NT-1:0] enable_mask;
    logic [TW-1:0] timeout_cycles;
    logic          test_start, test_abort, log_valid, busy, run_done, all_pass;
    logic [IW-1:0] test_id, log_id;
    logic [1:0]    log_status;
    logic [CW-1:0] pass_count, fail_count, timeout_count;

    unit_test_run_scheduler #(.NUM_TESTS(NT), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .enable_mask(enable_mask),
        .timeout_cycles(timeout_cycles), .abort_req(abort_req),
        .test_start(test_start), .test_abort(test_abort), .test_id(test_id),
        .test_done(test_done), .test_pass(test_pass),
        .log_valid(log_valid), .log_ready(log_ready), .log_id(log_id),
        .log_status(log_status), .busy(busy), .run_done(run_done),
        .all_pass(all_pass), .pass_count(pass_count), .fail_count(fail_count),
        .timeout_count(timeout_count)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Per-slot plan: cycles from test_start to done (0 = never), and verdict.
    int plan_d[NT];
    bit plan_p[NT];
    int tmo_m;
    int exp_ids[$];
    bit in_test, exp_to, pend_hs, m_abort, m_all_pass, rand_rdy;
    int cur_id, age, res_age, exp_st, m_pass, m_fail, m_to, hold_left, cyc, start_cyc;
    int ts_count, abort_count, lv_cycles, first_ts_cyc, rd_cyc, abort_age, rd_count;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic observe();
        if (pend_hs) begin
            pend_hs = 1'b0;
            case (exp_st)
                1: m_pass++;
                2: m_fail++;
                default: m_to++;
            endcase
            in_test = 1'b0;
        end
        if (rst) begin
            in_test = 1'b0; exp_ids.delete();
            m_pass = 0; m_fail = 0; m_to = 0; m_all_pass = 1'b0; m_abort = 1'b0;
            chk("rst_outputs", int'({test_start, test_abort, test_id, log_valid, log_id, log_status,
                busy, run_done, all_pass, pass_count, fail_count, timeout_count}), 0);
            return;
        end
        if (in_test) age++;
        if (test_start) begin
            ts_count++;
            chk("ts_allowed", int'(!in_test && !m_abort && exp_ids.size() > 0), 1);
            chk("ts_busy", int'(busy), 1);
            if (exp_ids.size() > 0) begin
                chk("ts_id", int'(test_id), exp_ids[0]);
                cur_id = exp_ids.pop_front();
                if (first_ts_cyc < 0) first_ts_cyc = cyc;
                in_test = 1'b1;
                age     = 0;
                exp_to  = (plan_d[cur_id] == 0) || (tmo_m != 0 && plan_d[cur_id] >= tmo_m);
                res_age = exp_to ? tmo_m : plan_d[cur_id] + 1;
                exp_st  = exp_to ? 3 : (plan_p[cur_id] ? 1 : 2);
            end
        end
        chk("test_abort", int'(test_abort), (in_test && exp_to && age == tmo_m) ? 1 : 0);
        if (test_abort) begin
            abort_count++;
            abort_age = age;
        end
        chk("log_valid", int'(log_valid), (in_test && age >= res_age) ? 1 : 0);
        if (log_valid && in_test) begin
            lv_cycles++;
            chk("log_id", int'(log_id), cur_id);
            chk("log_status", int'(log_status), exp_st);
        end
        if (in_test) chk("busy_in_test", int'(busy), 1);
        if (run_done) begin
            rd_count++;
            rd_cyc = cyc;
            chk("rd_when", int'(!in_test && (m_abort || exp_ids.size() == 0)), 1);
            chk("rd_busy", int'(busy), 0);
            m_all_pass = (m_fail == 0 && m_to == 0);
        end
        chk("pass_count", int'(pass_count), m_pass);
        chk("fail_count", int'(fail_count), m_fail);
        chk("timeout_count", int'(timeout_count), m_to);
        chk("all_pass", int'(all_pass), int'(m_all_pass));
    endtask

    task automatic drive();
        if (log_valid && hold_left > 0) begin
            log_ready = 1'b0;
            hold_left--;
        end else if (rand_rdy) begin
            log_ready = ($urandom_range(0, 3) != 0);
        end else begin
            log_ready = 1'b1;
        end
        if (log_valid && log_ready && in_test) pend_hs = 1'b1;
        test_done = in_test && !exp_to && (age == plan_d[cur_id]);
        test_pass = in_test ? plan_p[cur_id] : 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        observe();
        drive();
    endtask

    task automatic run(input logic [NT-1:0] mask, input int tmo, input int hold, input bit rr,
                       input int abort_slot, input int rst_slot);
        bit sent = 1'b0;
        tmo_m = tmo;
        exp_ids.delete();
        for (int i = 0; i < NT; i++) if (mask[i]) exp_ids.push_back(i);
        m_pass = 0; m_fail = 0; m_to = 0; m_all_pass = 1'b0; m_abort = 1'b0;
        hold_left = hold; rand_rdy = rr;
        ts_count = 0; abort_count = 0; lv_cycles = 0; first_ts_cyc = -1;
        rd_cyc = -1; rd_count = 0; abort_age = -1;
        enable_mask = mask;
        timeout_cycles = TW'(tmo);
        start_cyc = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 500 && rd_count == 0; k++) begin
            if (rst_slot >= 0 && in_test && cur_id == rst_slot && age == 3) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                return;
            end
            if (abort_slot >= 0 && !sent && in_test && cur_id == abort_slot && age == 2) begin
                abort_req = 1'b1;
                m_abort = 1'b1;
                sent = 1'b1;
                step();
                abort_req = 1'b0;
            end else begin
                step();
            end
        end
        if (rd_count == 0) chk("run_finished", 0, 1);
        step();
        step();
        chk("single_run_done", rd_count, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort_req = 1'b0; test_done = 1'b0; test_pass = 1'b0;
        log_ready = 1'b0; enable_mask = '0; timeout_cycles = '0;
        cyc = 0; in_test = 1'b0; pend_hs = 1'b0; exp_to = 1'b0; cur_id = 0; age = 0;
        res_age = 0; exp_st = 0; hold_left = 0; rand_rdy = 1'b0; tmo_m = 0;
        m_pass = 0; m_fail = 0; m_to = 0; m_all_pass = 1'b0; m_abort = 1'b0;
        ts_count = 0; abort_count = 0; lv_cycles = 0; first_ts_cyc = -1;
        rd_cyc = -1; rd_count = 0; abort_age = -1; start_cyc = 0;
        for (int i = 0; i < NT; i++) begin plan_d[i] = 3; plan_p[i] = 1'b1; end
        step();
        step();
        rst = 1'b0;
        step();

        // All four slots pass after 3 cycles.
        for (int i = 0; i < NT; i++) begin plan_d[i] = 3; plan_p[i] = 1'b1; end
        run(4'b1111, 10, 0, 1'b0, -1, -1);
        chk("s1_pass_count", int'(pass_count), 4);
        chk("s1_all_pass", int'(all_pass), 1);
        chk("s1_launch_latency", first_ts_cyc - start_cyc, 2);
        chk("s1_launches", ts_count, 4);

        // Slot 1 hangs and times out, slot 3 fails.
        plan_d[1] = 0; plan_d[3] = 2; plan_p[3] = 1'b0;
        run(4'b1010, 5, 0, 1'b0, -1, -1);
        chk("s2_timeout_count", int'(timeout_count), 1);
        chk("s2_fail_count", int'(fail_count), 1);
        chk("s2_all_pass", int'(all_pass), 0);
        chk("s2_abort_age", abort_age, 5);
        chk("s2_abort_pulses", abort_count, 1);

        // Logger stalls the first result for 7 cycles.
        for (int i = 0; i < NT; i++) begin plan_d[i] = 2; plan_p[i] = 1'b1; end
        run(4'b0011, 0, 7, 1'b0, -1, -1);
        chk("s3_valid_cycles", lv_cycles, 9);
        chk("s3_pass_count", int'(pass_count), 2);

        // Done lands on the same edge as the timeout.
        plan_d[0] = 3; plan_p[0] = 1'b1; plan_d[1] = 3; plan_p[1] = 1'b0;
        run(4'b0011, 4, 0, 1'b0, -1, -1);
        chk("s4_abort_pulses", abort_count, 0);
        chk("s4_timeout_count", int'(timeout_count), 0);
        chk("s4_pass_count", int'(pass_count), 1);
        chk("s4_fail_count", int'(fail_count), 1);

        // Abort request while slot 1 is running.
        for (int i = 0; i < NT; i++) begin plan_d[i] = 4; plan_p[i] = 1'b1; end
        run(4'b1111, 20, 0, 1'b1, 1, -1);
        chk("s5_launches", ts_count, 2);
        chk("s5_logged", int'(pass_count) + int'(fail_count), 2);

        for (int r = 0; r < 20; r++) begin
            int tmo;
            int ab;
            tmo = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 12));
            for (int i = 0; i < NT; i++) begin
                plan_d[i] = $urandom_range(1, 15);
                if (tmo != 0 && $urandom_range(0, 3) == 0) plan_d[i] = 0;
                plan_p[i] = 1'($urandom_range(0, 1));
            end
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NT - 1)) : -1;
            run(NT'($urandom_range(0, 15)), tmo, $urandom_range(0, 3), 1'b1, ab, -1);
        end

        // Reset in the middle of slot 2, then an empty run.
        for (int i = 0; i < NT; i++) begin plan_d[i] = 30; plan_p[i] = 1'b1; end
        run(4'b1111, 0, 0, 1'b0, -1, 2);
        step();
        step();
        chk("s6_busy_after_rst", int'(busy), 0);
        chk("s6_log_valid_after_rst", int'(log_valid), 0);
        run(4'b0000, 0, 0, 1'b0, -1, -1);
        chk("s6_empty_latency", rd_cyc - start_cyc, 2);
        chk("s6_empty_all_pass", int'(all_pass), 1);
        chk("s6_empty_counts", int'(pass_count) + int'(fail_count) + int'(timeout_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
